// File: rtl/game_pkg.sv
// game_pkg: shared state encodings, BCD width and default game constants
package game_pkg;
  typedef enum logic [2:0] {
    ST_ATTRACT     = 3'd0,
    ST_SERVE       = 3'd1,
    ST_PLAYING     = 3'd2,
    ST_LIFE_LOST   = 3'd3,
    ST_LEVEL_CLEAR = 3'd4,
    ST_GAME_OVER   = 3'd5
  } state_t;
  localparam int BCD_W = 4;
  localparam int DEF_NUM_BRICKS = 40;
  localparam int DEF_MAX_LIVES = 3;
endpackage

// File: rtl/bcd_score_accum.sv
// bcd_score_accum: 4-digit ripple BCD accumulator saturating at 9999
module bcd_score_accum
  import game_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        add_en,
  input  logic [3:0]  add_val,
  output logic [15:0] score
);
  logic [15:0] nxt;
  logic [4:0] s;
  logic c;
  // ripple the addend through the digits with decimal carry; carry out means overflow
  always_comb begin
    nxt = '0;
    s = '0;
    c = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s = {1'b0, score[BCD_W*i +: BCD_W]} + {1'b0, (i == 0) ? add_val : 4'd0} + {4'd0, c};
      c = s > 5'd9;
      nxt[BCD_W*i +: BCD_W] = c ? 4'(s - 5'd10) : s[3:0];
    end
  end
  // clear wins over add; an overflowing add pins the score at 9999
  always_ff @(posedge clk) begin
    if (rst || clear) score <= '0;
    else if (add_en) score <= c ? 16'h9999 : nxt;
  end
endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: breakout game-flow controller for lives, score, level and bricks
module game_sequencer
  import game_pkg::*;
#(
  parameter int NUM_BRICKS = DEF_NUM_BRICKS,
  parameter int MAX_LIVES = DEF_MAX_LIVES,
  parameter int POINTS_PER_BRICK = 1,
  parameter int PAUSE_FRAMES = 60,
  parameter int MAX_LEVEL = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_pulse,
  input  logic        btn_action,
  input  logic        brick_hit,
  input  logic        ball_lost,
  output logic        play_enable,
  output logic        ball_reset,
  output logic        wall_reload,
  output logic [1:0]  lives,
  output logic [15:0] score,
  output logic [2:0]  level,
  output logic [2:0]  state_o
);
  localparam logic [6:0] BRICKS_LD = 7'(NUM_BRICKS);
  localparam logic [5:0] PAUSE_LD = 6'(PAUSE_FRAMES - 1);
  localparam logic [1:0] LIVES_LD = 2'(MAX_LIVES);
  localparam logic [2:0] LEVEL_MAX = 3'(MAX_LEVEL);
  state_t state;
  logic [6:0] bricks_left;
  logic [5:0] pause_cnt;
  logic start;
  logic hit_ok;
  assign start = frame_pulse && btn_action && state == ST_ATTRACT;
  assign hit_ok = brick_hit && state == ST_PLAYING;
  assign state_o = state;
  bcd_score_accum u_score (
    .clk(clk),
    .rst(rst),
    .clear(start),
    .add_en(hit_ok),
    .add_val(4'(POINTS_PER_BRICK)),
    .score(score)
  );
  // game flow: hits count on any cycle, transitions only on frame_pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_ATTRACT;
      lives <= LIVES_LD;
      level <= '0;
      bricks_left <= BRICKS_LD;
      pause_cnt <= '0;
      play_enable <= 1'b0;
      ball_reset <= 1'b0;
      wall_reload <= 1'b0;
    end else begin
      ball_reset <= 1'b0;
      wall_reload <= 1'b0;
      if (hit_ok && bricks_left != 7'd0) bricks_left <= bricks_left - 7'd1;
      if (frame_pulse) begin
        case (state)
          ST_ATTRACT: if (btn_action) begin
            state <= ST_SERVE;
            lives <= LIVES_LD;
            level <= '0;
            bricks_left <= BRICKS_LD;
            ball_reset <= 1'b1;
            wall_reload <= 1'b1;
          end
          ST_SERVE: if (btn_action) begin
            state <= ST_PLAYING;
            play_enable <= 1'b1;
          end
          ST_PLAYING: if (bricks_left == 7'd0) begin
            state <= ST_LEVEL_CLEAR;
            pause_cnt <= PAUSE_LD;
            play_enable <= 1'b0;
          end else if (ball_lost) begin
            state <= ST_LIFE_LOST;
            pause_cnt <= PAUSE_LD;
            play_enable <= 1'b0;
            lives <= lives - 2'd1;
          end
          ST_LIFE_LOST: if (pause_cnt != 6'd0) pause_cnt <= pause_cnt - 6'd1;
          else if (lives == 2'd0) begin
            state <= ST_GAME_OVER;
            pause_cnt <= PAUSE_LD;
          end else begin
            state <= ST_SERVE;
            ball_reset <= 1'b1;
          end
          ST_LEVEL_CLEAR: if (pause_cnt != 6'd0) pause_cnt <= pause_cnt - 6'd1;
          else begin
            state <= ST_SERVE;
            level <= (level == LEVEL_MAX) ? level : level + 3'd1;
            bricks_left <= BRICKS_LD;
            ball_reset <= 1'b1;
            wall_reload <= 1'b1;
          end
          ST_GAME_OVER: if (pause_cnt != 6'd0) pause_cnt <= pause_cnt - 6'd1;
          else state <= ST_ATTRACT;
          default: state <= ST_ATTRACT;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: randomized scoreboard bench against a behavioural game model
module tb_game_sequencer;
  localparam int NB = 3;
  localparam int ML = 3;
  localparam int PTS = 7;
  localparam int PF = 60;
  localparam int MLV = 7;
  typedef struct packed {
    logic pe;
    logic br;
    logic wr;
    logic [1:0] lv;
    logic [15:0] sc;
    logic [2:0] lev;
    logic [2:0] st;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frame_pulse = 1'b0;
  logic btn_action = 1'b0;
  logic brick_hit = 1'b0;
  logic ball_lost = 1'b0;
  logic play_enable, ball_reset, wall_reload;
  logic [1:0] lives;
  logic [15:0] score;
  logic [2:0] level, state_o;
  int checks = 0;
  int failures = 0;
  exp_t q[$];
  int m_state, m_lives, m_score, m_level, m_bricks, m_pause, m_br, m_wr;
  game_sequencer #(.NUM_BRICKS(NB), .MAX_LIVES(ML), .POINTS_PER_BRICK(PTS),
                   .PAUSE_FRAMES(PF), .MAX_LEVEL(MLV)) dut (
    .clk(clk), .rst(rst), .frame_pulse(frame_pulse), .btn_action(btn_action),
    .brick_hit(brick_hit), .ball_lost(ball_lost), .play_enable(play_enable),
    .ball_reset(ball_reset), .wall_reload(wall_reload), .lives(lives),
    .score(score), .level(level), .state_o(state_o)
  );
  always #5 clk = ~clk;
  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction
  // game rules at frame granularity: 0 attract,1 serve,2 playing,3 life lost,4 level clear,5 game over
  task automatic model_step(input logic r, input logic fp, input logic b, input logic h, input logic l);
    int s0, b0;
    exp_t e;
    s0 = m_state;
    b0 = m_bricks;
    m_br = 0;
    m_wr = 0;
    if (r) begin
      m_state = 0; m_lives = ML; m_score = 0; m_level = 0; m_bricks = NB; m_pause = 0;
    end else begin
      if (s0 == 2 && h) begin
        if (m_bricks > 0) m_bricks--;
        m_score = (m_score + PTS > 9999) ? 9999 : m_score + PTS;
      end
      if (fp) begin
        if (s0 == 0 && b) begin
          m_state = 1; m_lives = ML; m_score = 0; m_level = 0; m_bricks = NB; m_br = 1; m_wr = 1;
        end else if (s0 == 1 && b) m_state = 2;
        else if (s0 == 2 && b0 == 0) begin
          m_state = 4; m_pause = PF - 1;
        end else if (s0 == 2 && l) begin
          m_state = 3; m_pause = PF - 1; m_lives--;
        end else if (s0 >= 3) begin
          if (m_pause > 0) m_pause--;
          else if (s0 == 3 && m_lives == 0) begin
            m_state = 5; m_pause = PF - 1;
          end else if (s0 == 3) begin
            m_state = 1; m_br = 1;
          end else if (s0 == 4) begin
            m_state = 1; m_level = (m_level < MLV) ? m_level + 1 : MLV; m_bricks = NB; m_br = 1; m_wr = 1;
          end else m_state = 0;
        end
      end
    end
    e.pe = (m_state == 2);
    e.br = m_br[0];
    e.wr = m_wr[0];
    e.lv = 2'(m_lives);
    e.sc = to_bcd(m_score);
    e.lev = 3'(m_level);
    e.st = 3'(m_state);
    q.push_back(e);
  endtask
  task automatic drive(input logic r, input logic fp, input logic b, input logic h, input logic l);
    @(negedge clk);
    rst = r; frame_pulse = fp; btn_action = b; brick_hit = h; ball_lost = l;
    model_step(r, fp, b, h, l);
  endtask
  // monitor: every edge presents a full output set; compare it with the oldest expectation
  initial begin
    exp_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        a = {play_enable, ball_reset, wall_reload, lives, score, level, state_o};
        checks++;
        if (a !== e) begin
          failures++;
          $display("FAIL outputs t=%0t act pe=%b br=%b wr=%b lives=%0d score=%h level=%0d st=%0d exp pe=%b br=%b wr=%b lives=%0d score=%h level=%0d st=%0d",
                   $time, a.pe, a.br, a.wr, a.lv, a.sc, a.lev, a.st, e.pe, e.br, e.wr, e.lv, e.sc, e.lev, e.st);
        end
      end
    end
  end
  initial begin
    int n;
    repeat (3) drive(1, 0, 0, 0, 0);
    drive(0, 1, 1, 0, 0);
    repeat (3) drive(0, 0, 0, 0, 0);
    drive(0, 1, 1, 0, 0);
    repeat (5) drive(0, 0, 0, 1, 0);
    drive(0, 1, 0, 1, 1);
    repeat (1500) drive(0, 0, 0, 1, 0);
    repeat (130) drive(0, 1, 0, 0, 1);
    for (int i = 0; i < 1200; i++) drive(0, (i % 3) == 0, 1, 0, 1);
    n = 0;
    while (!(m_state == 3 && m_pause == 20) && n < 20000) begin
      drive(0, (n % 2) == 0, 1, 0, 1);
      n++;
    end
    checks++;
    if (n >= 20000) begin
      failures++;
      $display("FAIL reach_life_lost_pause20 act iterations=%0d req below 20000", n);
    end
    drive(1, 1, 1, 1, 1);
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 25000; i++)
      drive($urandom_range(0, 2999) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0);
    @(posedge clk);
    @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain act pending=%0d req 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
